multicycle_control_unit: RTL and testbench

//  Multi-cycle RV32I control FSM. It sequences fetch, decode, execute, memory and writeback over several clocks.

---
 rtl/multicycle_control_unit_if.sv | 43 ++++
 rtl/multicycle_control_unit.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: IR fields, ALU flags and memory ready in,
// per-state datapath strobes and the trap flag out.
interface multicycle_control_unit_if #(
    parameter int ALU_OP_W = 3
);
    logic [6:0]          op;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                alu_zero;
    logic                alu_lt;
    logic                alu_ltu;
    logic                mem_ready;
    logic                pc_write;
    logic                adr_src;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write_enable;
    logic [2:0]          imm_src;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          result_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal_instr;

    modport master (
        input  op, funct3, funct7,
        input  alu_zero, alu_lt, alu_ltu, mem_ready,
        output pc_write, adr_src, mem_read, mem_write,
        output ir_write, reg_write_enable, imm_src,
        output alu_src_a, alu_src_b, result_src,
        output alu_op, illegal_instr
    );

    modport slave (
        output op, funct3, funct7,
        output alu_zero, alu_lt, alu_ltu, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write,
        input  ir_write, reg_write_enable, imm_src,
        input  alu_src_a, alu_src_b, result_src,
        input  alu_op, illegal_instr
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing over a shared memory port, with a sticky illegal-op trap.
module multicycle_control_unit #(
    parameter int ALU_OP_W    = 3,
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit BRANCH_EXT  = 1'b1
) (
    input logic                       clock_i,
    input logic                       reset_i,
    multicycle_control_unit_if.master ctl
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] A_ADD  = 3'b000;
    localparam logic [2:0] A_SUB  = 3'b001;
    localparam logic [2:0] A_AND  = 3'b010;
    localparam logic [2:0] A_OR   = 3'b011;
    localparam logic [2:0] A_XOR  = 3'b100;
    localparam logic [2:0] A_SLT  = 3'b101;
    localparam logic [2:0] A_SLTU = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ,
        S_MEM_WB, S_MEM_WRITE, S_EXEC_R, S_EXEC_I,
        S_ALU_WB, S_BRANCH, S_JAL, S_TRAP
    } state_e;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       rdy, taken, br_ok;
    logic [2:0] alu3;
    logic       unused_f7;

    assign rdy       = MEM_WAIT_EN ? ctl.mem_ready : 1'b1;
    assign unused_f7 = ^{ctl.funct7[6], ctl.funct7[4:0]};

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (ctl.funct3)
            3'b000:  taken = ctl.alu_zero;
            3'b001:  taken = !ctl.alu_zero;
            3'b100:  taken = ctl.alu_lt;
            3'b101:  taken = !ctl.alu_lt;
            3'b110:  taken = ctl.alu_ltu;
            3'b111:  taken = !ctl.alu_ltu;
            default: br_ok = 1'b0;
        endcase
        if (!BRANCH_EXT && ctl.funct3 != 3'b000) br_ok = 1'b0;
    end

    always_comb begin
        state_d              = state_q;
        ctl.pc_write         = 1'b0;
        ctl.adr_src          = 1'b0;
        ctl.mem_read         = 1'b0;
        ctl.mem_write        = 1'b0;
        ctl.ir_write         = 1'b0;
        ctl.reg_write_enable = 1'b0;
        ctl.imm_src          = 3'b000;
        ctl.alu_src_a        = 2'b00;
        ctl.alu_src_b        = 2'b00;
        ctl.result_src       = 2'b00;
        alu3                 = A_ADD;
        unique case (state_q)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
                if (rdy) begin
                    ctl.ir_write   = 1'b1;
                    ctl.pc_write   = 1'b1;
                    ctl.alu_src_b  = 2'b10;
                    ctl.result_src = 2'b10;
                    state_d        = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b01;
                ctl.imm_src   = (ctl.op == OP_JAL) ? 3'b011 : 3'b010;
                case (ctl.op)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                // op[5] separates store (0100011) from load (0000011)
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                ctl.imm_src   = ctl.op[5] ? 3'b001 : 3'b000;
                state_d       = ctl.op[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctl.adr_src  = 1'b1;
                ctl.mem_read = 1'b1;
                if (rdy) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.result_src       = 2'b01;
                ctl.reg_write_enable = 1'b1;
                state_d              = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.adr_src   = 1'b1;
                ctl.mem_write = 1'b1;
                if (rdy) state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
                state_d       = S_ALU_WB;
                case (ctl.funct3)
                    3'b000:  alu3 = (ctl.op[5] && ctl.funct7[5]) ? A_SUB : A_ADD;
                    3'b010:  alu3 = A_SLT;
                    3'b011:  alu3 = A_SLTU;
                    3'b100:  alu3 = A_XOR;
                    3'b110:  alu3 = A_OR;
                    3'b111:  alu3 = A_AND;
                    default: state_d = S_TRAP;
                endcase
            end
            S_ALU_WB: begin
                ctl.reg_write_enable = 1'b1;
                state_d              = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 2'b10;
                alu3          = A_SUB;
                if (br_ok) begin
                    ctl.pc_write = taken;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_JAL: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                ctl.pc_write  = 1'b1;
                state_d       = S_ALU_WB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign illegal_d         = illegal_q || (state_d == S_TRAP);
    assign ctl.illegal_instr = illegal_q;
    assign ctl.alu_op        = ALU_OP_W'(alu3);
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: each task walks an
// instruction through its states and checks the packed strobe vector.
module tb_multicycle_control_unit;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // {pc_w,adr,mrd,mwr,irw,rwe, imm, srcA, srcB, res, alu, illegal}
    localparam logic [18:0] V_F_NR   = 19'b0_0_1_0_0_0_000_00_00_00_000_0;
    localparam logic [18:0] V_F_R    = 19'b1_0_1_0_1_0_000_00_10_10_000_0;
    localparam logic [18:0] V_DEC    = 19'b0_0_0_0_0_0_010_01_01_00_000_0;
    localparam logic [18:0] V_DEC_J  = 19'b0_0_0_0_0_0_011_01_01_00_000_0;
    localparam logic [18:0] V_WB     = 19'b0_0_0_0_0_1_000_00_00_00_000_0;
    localparam logic [18:0] V_MADR_L = 19'b0_0_0_0_0_0_000_10_01_00_000_0;
    localparam logic [18:0] V_MADR_S = 19'b0_0_0_0_0_0_001_10_01_00_000_0;
    localparam logic [18:0] V_MRD    = 19'b0_1_1_0_0_0_000_00_00_00_000_0;
    localparam logic [18:0] V_MWB    = 19'b0_0_0_0_0_1_000_00_00_01_000_0;
    localparam logic [18:0] V_MWR    = 19'b0_1_0_1_0_0_000_00_00_00_000_0;
    localparam logic [18:0] V_BR_T   = 19'b1_0_0_0_0_0_000_10_00_00_001_0;
    localparam logic [18:0] V_BR_N   = 19'b0_0_0_0_0_0_000_10_00_00_001_0;
    localparam logic [18:0] V_JAL    = 19'b1_0_0_0_0_0_000_01_10_00_000_0;
    localparam logic [18:0] V_TRAP   = 19'b0_0_0_0_0_0_000_00_00_00_000_1;

    logic clk;
    logic rst;
    logic rst0;
    int   n_cmp;
    int   n_bad;

    multicycle_control_unit_if #(.ALU_OP_W(3)) bus ();
    multicycle_control_unit_if #(.ALU_OP_W(3)) bus0 ();

    multicycle_control_unit #(
        .ALU_OP_W(3), .MEM_WAIT_EN(1'b1), .BRANCH_EXT(1'b1)
    ) u_dut (
        .clock_i(clk), .reset_i(rst), .ctl(bus)
    );

    multicycle_control_unit #(
        .ALU_OP_W(3), .MEM_WAIT_EN(1'b1), .BRANCH_EXT(1'b0)
    ) u_dut0 (
        .clock_i(clk), .reset_i(rst0), .ctl(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] outs_m();
        return {bus.pc_write, bus.adr_src, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write_enable, bus.imm_src,
                bus.alu_src_a, bus.alu_src_b, bus.result_src,
                bus.alu_op, bus.illegal_instr};
    endfunction

    function automatic logic [18:0] outs_0();
        return {bus0.pc_write, bus0.adr_src, bus0.mem_read, bus0.mem_write,
                bus0.ir_write, bus0.reg_write_enable, bus0.imm_src,
                bus0.alu_src_a, bus0.alu_src_b, bus0.result_src,
                bus0.alu_op, bus0.illegal_instr};
    endfunction

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7);
        bus.op  = o;  bus.funct3  = f3; bus.funct7  = f7;
        bus0.op = o;  bus0.funct3 = f3; bus0.funct7 = f7;
    endtask

    task automatic set_rdy(input logic r);
        bus.mem_ready  = r;
        bus0.mem_ready = r;
    endtask

    task automatic set_flags(input logic z, input logic lt, input logic ltu);
        bus.alu_zero  = z; bus.alu_lt  = lt; bus.alu_ltu  = ltu;
        bus0.alu_zero = z; bus0.alu_lt = lt; bus0.alu_ltu = ltu;
    endtask

    task automatic test_reset();
        logic [18:0] e [6] = '{V_F_NR, V_F_NR, V_F_R, V_DEC,
                               19'b0_0_0_0_0_0_000_10_00_00_000_0, V_WB};
        logic        r [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        set_instr(OP_R, 3'b000, 7'h00);
        rst = 1'b1;
        set_rdy(1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_rdy(r[i]);
            #1;
            n_cmp++;
            if (outs_m() !== e[i]) begin
                n_bad++;
                $display("FAIL reset c%0d got %b want %b", i, outs_m(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_alu();
        logic [6:0] t_op [8] = '{OP_R, OP_R, OP_I, OP_I, OP_R, OP_I, OP_R, OP_I};
        logic [2:0] t_f3 [8] = '{3'b000, 3'b000, 3'b000, 3'b010,
                                 3'b011, 3'b100, 3'b110, 3'b111};
        logic [6:0] t_f7 [8] = '{7'h00, 7'h20, 7'h20, 7'h00,
                                 7'h00, 7'h00, 7'h00, 7'h00};
        logic [2:0] t_al [8] = '{3'b000, 3'b001, 3'b000, 3'b101,
                                 3'b110, 3'b100, 3'b011, 3'b010};
        logic [18:0] e [4];
        for (int k = 0; k < 8; k++) begin
            set_instr(t_op[k], t_f3[k], t_f7[k]);
            e[0] = V_F_R;
            e[1] = V_DEC;
            e[2] = {9'b0, 2'b10, (t_op[k] == OP_I) ? 2'b01 : 2'b00,
                    2'b00, t_al[k], 1'b0};
            e[3] = V_WB;
            for (int i = 0; i < 4; i++) begin
                set_rdy(i == 0);
                #1;
                n_cmp++;
                if (outs_m() !== e[i]) begin
                    n_bad++;
                    $display("FAIL alu%0d c%0d got %b want %b",
                             k, i, outs_m(), e[i]);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [18:0] e [8] = '{V_F_R, V_DEC, V_MADR_L, V_MRD,
                               V_MRD, V_MRD, V_MRD, V_MWB};
        logic        r [8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b1};
        set_instr(OP_LOAD, 3'b010, 7'h00);
        for (int i = 0; i < 8; i++) begin
            set_rdy(r[i]);
            #1;
            n_cmp++;
            if (outs_m() !== e[i]) begin
                n_bad++;
                $display("FAIL lw c%0d got %b want %b", i, outs_m(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sw();
        logic [18:0] e [6] = '{V_F_R, V_DEC, V_MADR_S, V_MWR, V_MWR, V_F_NR};
        logic        r [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        set_instr(OP_STORE, 3'b010, 7'h00);
        for (int i = 0; i < 6; i++) begin
            set_rdy(r[i]);
            #1;
            n_cmp++;
            if (outs_m() !== e[i]) begin
                n_bad++;
                $display("FAIL sw c%0d got %b want %b", i, outs_m(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        logic [2:0] t_f3 [7] = '{3'b001, 3'b001, 3'b000, 3'b100,
                                 3'b101, 3'b110, 3'b111};
        logic [2:0] t_fl [7] = '{3'b000, 3'b100, 3'b100, 3'b010,
                                 3'b010, 3'b000, 3'b000};
        logic       t_tk [7] = '{1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b1};
        logic [18:0] e [3];
        for (int k = 0; k < 7; k++) begin
            set_instr(OP_BR, t_f3[k], 7'h00);
            set_flags(t_fl[k][2], t_fl[k][1], t_fl[k][0]);
            e[0] = V_F_R;
            e[1] = V_DEC;
            e[2] = t_tk[k] ? V_BR_T : V_BR_N;
            for (int i = 0; i < 3; i++) begin
                set_rdy(i == 0);
                #1;
                n_cmp++;
                if (outs_m() !== e[i]) begin
                    n_bad++;
                    $display("FAIL br%0d c%0d got %b want %b",
                             k, i, outs_m(), e[i]);
                end
                @(posedge clk);
                #1;
            end
        end
        set_flags(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_jal();
        logic [18:0] e [5] = '{V_F_R, V_DEC_J, V_JAL, V_WB, V_F_NR};
        set_instr(OP_JAL, 3'b000, 7'h00);
        for (int i = 0; i < 5; i++) begin
            set_rdy(i == 0);
            #1;
            n_cmp++;
            if (outs_m() !== e[i]) begin
                n_bad++;
                $display("FAIL jal c%0d got %b want %b", i, outs_m(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_ext0();
        set_instr(OP_BR, 3'b001, 7'h00);
        set_flags(1'b0, 1'b0, 1'b0);
        rst0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_rdy(i == 0);
            #1;
            if (i == 0) begin
                n_cmp++;
                if (outs_0() !== V_F_R) begin
                    n_bad++;
                    $display("FAIL ext0 fetch got %b want %b", outs_0(), V_F_R);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (bus0.pc_write !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ext0 pc_write got %b want 0", bus0.pc_write);
                end
                n_cmp++;
                if (outs_m() !== V_BR_T) begin
                    n_bad++;
                    $display("FAIL ext1 bne got %b want %b", outs_m(), V_BR_T);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (outs_0() !== V_TRAP) begin
                    n_bad++;
                    $display("FAIL ext0 trap got %b want %b", outs_0(), V_TRAP);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_trap();
        set_instr(7'b0000000, 3'b000, 7'h00);
        for (int i = 0; i < 12; i++) begin
            set_rdy((i == 0) || (i % 2 == 1));
            #1;
            n_cmp++;
            if (outs_m() !== ((i == 0) ? V_F_R : (i == 1) ? V_DEC : V_TRAP)) begin
                n_bad++;
                $display("FAIL trap c%0d got %b", i, outs_m());
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_rdy(1'b0);
        #1;
        n_cmp++;
        if (outs_m() !== V_F_NR) begin
            n_bad++;
            $display("FAIL trap_clear got %b want %b", outs_m(), V_F_NR);
        end
        @(posedge clk);
        #1;
        set_instr(OP_I, 3'b001, 7'h00);
        for (int i = 0; i < 4; i++) begin
            set_rdy(i == 0);
            #1;
            if (i == 3) begin
                n_cmp++;
                if (outs_m() !== V_TRAP) begin
                    n_bad++;
                    $display("FAIL shift_trap got %b want %b", outs_m(), V_TRAP);
                end
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [18:0] e [4] = '{V_F_R, V_DEC, V_MADR_S, V_MWR};
        set_instr(OP_STORE, 3'b000, 7'h00);
        for (int i = 0; i < 4; i++) begin
            set_rdy(i == 0);
            #1;
            n_cmp++;
            if (outs_m() !== e[i]) begin
                n_bad++;
                $display("FAIL rstwr c%0d got %b want %b", i, outs_m(), e[i]);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (outs_m() !== V_F_NR) begin
                n_bad++;
                $display("FAIL rstwr_after c%0d got %b want %b",
                         i, outs_m(), V_F_NR);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        rst0  = 1'b1;
        set_instr(7'h00, 3'b000, 7'h00);
        set_flags(1'b0, 1'b0, 1'b0);
        set_rdy(1'b0);
        test_reset();
        test_alu();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jal();
        test_branch_ext0();
        test_trap();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
